instr_fetch: RTL and testbench

//  Instruction fetch stage: owns the PC and issues one word read at a time to instruction memory.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_skid_buf.sv | 53 +++++
 rtl/instr_fetch.sv | 142 ++++++++++++++
 tb/tb_instr_fetch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: RV32 opcodes used by fetch/decode/control, the NOP word
// shown on an empty IF/ID register, and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam logic [6:0] OPC_RT  = 7'b0110011;
  localparam logic [6:0] OPC_IT  = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// One-entry {pc, instr} holding slot for a fetched word that decode could not take yet.
// Latency 1 cycle write-to-full; clear wins over write, write wins over read.
module instr_fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [31:0]     wr_instr,
  input  logic            rd_en,
  input  logic            clr,
  output logic            full,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_instr
);

  logic            full_q, full_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (wr_en) begin
      full_d  = 1'b1;
      pc_d    = wr_pc;
      instr_d = wr_instr;
    end else if (rd_en) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full     = full_q;
  assign rd_pc    = pc_q;
  assign rd_instr = instr_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps one imem read outstanding, registers words into IF/ID.
// Accept-to-if_valid = rsp latency + 1; decode stall parks one word in the skid, branch flushes.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;

  logic            skid_full, skid_wr, skid_rd, skid_clr;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic            req_fire, rsp_load;

  // A parked word must drain before another fetch can be issued.
  assign imem_req_valid = !rst && (state_q == S_REQ) && !skid_full;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    skid_wr    = 1'b0;
    skid_rd    = 1'b0;
    skid_clr   = 1'b0;
    rsp_load   = 1'b0;

    if (branch_taken) begin
      pc_d       = branch_target & ~XLEN'(3);
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      skid_clr   = 1'b1;
      if (state_q == S_REQ) begin
        if (req_fire) begin
          state_d = S_WAIT;
          kill_d  = 1'b1;
        end
      end else if (imem_rsp_valid) begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end else begin
        kill_d = 1'b1;
      end
    end else begin
      if (state_q == S_REQ) begin
        if (req_fire) state_d = S_WAIT;
      end else if (imem_rsp_valid) begin
        state_d = S_REQ;
        if (kill_q) begin
          kill_d = 1'b0;
        end else begin
          pc_d = pc_q + XLEN'(4);
          if (!if_valid_q || !stall) begin
            rsp_load   = 1'b1;
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rsp_data;
          end else begin
            skid_wr = 1'b1;
          end
        end
      end

      // Decode took the current word (or IF/ID was empty): refill from skid or go empty.
      if (!stall && !rsp_load) begin
        if (skid_full) begin
          skid_rd    = 1'b1;
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc;
          if_instr_d = skid_instr;
        end else begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  instr_fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (skid_wr),
    .wr_pc    (pc_q),
    .wr_instr (imem_rsp_data),
    .rd_en    (skid_rd),
    .clr      (skid_clr),
    .full     (skid_full),
    .rd_pc    (skid_pc),
    .rd_instr (skid_instr)
  );

  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_opcode = if_instr_q[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus a streaming sequence with
// varying response latency, ready gaps and decode stalls.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W0 = {25'h0100001, OPC_IT};
  localparam logic [31:0] W1 = {25'h0041102, OPC_RT};
  localparam logic [31:0] W2 = {25'h0001403, OPC_LW};
  localparam logic [31:0] W3 = {25'h0082484, OPC_SW};
  localparam logic [31:0] W4 = {25'h0041088, OPC_BEQ};

  logic        clk = 1'b0;
  logic        rst, rdy, rv, bt, stall;
  logic [31:0] rdata, btgt;
  logic        req_valid, if_valid;
  logic [31:0] addr, if_pc, if_instr;
  logic [6:0]  if_opcode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (req_valid),
    .imem_req_ready (rdy),
    .imem_addr      (addr),
    .imem_rsp_valid (rv),
    .imem_rsp_data  (rdata),
    .branch_taken   (bt),
    .branch_target  (btgt),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode)
  );

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rdata;
    logic        bt;
    logic [31:0] btgt;
    logic        stall;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(int r, int y, int rsp, logic [31:0] d, int b, logic [31:0] t,
                             int s, int erq, logic [31:0] ea, int eiv, logic [31:0] ep,
                             logic [31:0] ei);
    vec_t x;
    x.rst = (r != 0);   x.rdy = (y != 0);   x.rv = (rsp != 0);  x.rdata = d;
    x.bt = (b != 0);    x.btgt = t;         x.stall = (s != 0);
    x.e_rqv = (erq != 0); x.e_addr = ea; x.e_ifv = (eiv != 0); x.e_pc = ep; x.e_instr = ei;
    return x;
  endfunction

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[24:0], OPC_IT};
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_pc, got, cyc, cnt, nacc;
    logic pend;
    logic [31:0] paddr;

    // r  y  rv d   bt tgt           st | rqv addr          ifv pc            instr
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 0,            0, 0,            NOP));
    vq.push_back(v(0, 1, 1, W0, 0, 0,            0,  0, 0,            0, 0,            NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 'h4,          1, 0,            W0));
    vq.push_back(v(0, 1, 1, W1, 0, 0,            0,  0, 'h4,          0, 0,            NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            1,  1, 'h8,          1, 'h4,          W1));
    vq.push_back(v(0, 1, 1, W2, 0, 0,            1,  0, 'h8,          1, 'h4,          W1));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            1,  0, 'hC,          1, 'h4,          W1));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  0, 'hC,          1, 'h4,          W1));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 'hC,          1, 'h8,          W2));
    vq.push_back(v(0, 1, 1, W3, 0, 0,            0,  0, 'hC,          0, 'h8,          NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 'h10,         1, 'hC,          W3));
    vq.push_back(v(0, 1, 0, 0,  1, 'h40,         0,  0, 'h10,         0, 'hC,          NOP));
    vq.push_back(v(0, 1, 1, W4, 0, 0,            0,  0, 'h40,         0, 'hC,          NOP));
    vq.push_back(v(0, 0, 0, 0,  0, 0,            0,  1, 'h40,         0, 'hC,          NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 'h40,         0, 'hC,          NOP));
    vq.push_back(v(0, 1, 1, W0, 0, 0,            0,  0, 'h40,         0, 'hC,          NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            1,  1, 'h44,         1, 'h40,         W0));
    vq.push_back(v(0, 1, 1, W1, 0, 0,            1,  0, 'h44,         1, 'h40,         W0));
    vq.push_back(v(0, 1, 0, 0,  1, 'h43,         1,  0, 'h48,         1, 'h40,         W0));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            1,  1, 'h40,         0, 'h40,         NOP));
    vq.push_back(v(0, 1, 1, W2, 0, 0,            0,  0, 'h40,         0, 'h40,         NOP));
    vq.push_back(v(0, 0, 0, 0,  0, 0,            0,  1, 'h44,         1, 'h40,         W2));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 'h44,         0, 'h40,         NOP));
    vq.push_back(v(0, 1, 1, W3, 1, 'h80,         0,  0, 'h44,         0, 'h40,         NOP));
    vq.push_back(v(0, 1, 0, 0,  1, 'h100,        0,  1, 'h80,         0, 'h40,         NOP));
    vq.push_back(v(0, 1, 1, W4, 0, 0,            0,  0, 'h100,        0, 'h40,         NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 'h100,        0, 'h40,         NOP));
    vq.push_back(v(0, 1, 1, W4, 0, 0,            0,  0, 'h100,        0, 'h40,         NOP));
    vq.push_back(v(0, 0, 0, 0,  0, 0,            0,  1, 'h104,        1, 'h100,        W4));
    vq.push_back(v(0, 0, 0, 0,  1, 'hFFFFFFFC,   0,  1, 'h104,        0, 'h100,        NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 'hFFFFFFFC,   0, 'h100,        NOP));
    vq.push_back(v(0, 1, 1, W1, 0, 0,            0,  0, 'hFFFFFFFC,   0, 'h100,        NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 0,            1, 'hFFFFFFFC,   W1));
    vq.push_back(v(0, 1, 1, W2, 0, 0,            0,  0, 0,            0, 'hFFFFFFFC,   NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            1,  1, 'h4,          1, 0,            W2));
    vq.push_back(v(1, 1, 0, 0,  0, 0,            1,  0, 'h4,          1, 0,            W2));
    vq.push_back(v(1, 1, 1, W3, 0, 0,            0,  0, 0,            0, 0,            NOP));
    vq.push_back(v(0, 0, 1, W4, 0, 0,            0,  1, 0,            0, 0,            NOP));
    vq.push_back(v(0, 1, 0, 0,  0, 0,            0,  1, 0,            0, 0,            NOP));
    vq.push_back(v(0, 1, 1, W0, 0, 0,            0,  0, 0,            0, 0,            NOP));
    vq.push_back(v(0, 0, 0, 0,  0, 0,            0,  1, 'h4,          1, 0,            W0));

    rst = 1'b1; rdy = 1'b1; rv = 1'b0; rdata = '0; bt = 1'b0; btgt = '0; stall = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset req_valid", -1, 32'(req_valid), 32'd0);
    chk("reset if_valid",  -1, 32'(if_valid),  32'd0);
    chk("reset if_pc",     -1, if_pc,          32'h0);
    chk("reset if_instr",  -1, if_instr,       NOP);
    chk("reset if_opcode", -1, 32'(if_opcode), 32'h13);
    next_cycle();

    foreach (vq[i]) begin
      rst = vq[i].rst; rdy = vq[i].rdy; rv = vq[i].rv; rdata = vq[i].rdata;
      bt = vq[i].bt; btgt = vq[i].btgt; stall = vq[i].stall;
      @(negedge clk);
      chk("req_valid", i, 32'(req_valid), 32'(vq[i].e_rqv));
      chk("imem_addr", i, addr,           vq[i].e_addr);
      chk("if_valid",  i, 32'(if_valid),  32'(vq[i].e_ifv));
      chk("if_pc",     i, if_pc,          vq[i].e_pc);
      chk("if_instr",  i, if_instr,       vq[i].e_instr);
      chk("if_opcode", i, 32'(if_opcode), 32'(vq[i].e_instr[6:0]));
      next_cycle();
    end

    // Streaming: latency 1..3, ready gaps, periodic stalls; every word delivered once, in order.
    rst = 1'b1; rdy = 1'b0; rv = 1'b0; bt = 1'b0; stall = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    exp_pc = 0; got = 0; cyc = 0; cnt = 0; nacc = 0; pend = 1'b0; paddr = '0;
    while (got < 8 && cyc < 400) begin
      rv = 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          rv = 1'b1;
          rdata = instr_of(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      rdy   = (cyc % 3 != 1);
      stall = (cyc % 5 == 2) || (cyc % 5 == 3);
      @(negedge clk);
      if (req_valid && rdy) begin
        pend  = 1'b1;
        cnt   = 1 + (nacc % 3);
        nacc++;
        paddr = addr;
      end
      if (if_valid && !stall) begin
        chk("stream if_pc",    got, if_pc,    32'(exp_pc));
        chk("stream if_instr", got, if_instr, instr_of(32'(exp_pc)));
        exp_pc += 4;
        got++;
      end
      next_cycle();
      cyc++;
    end
    if (got < 8) begin
      total++;
      bad++;
      $display("FAIL stream timeout: got %0d words, expected 8", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
